// File: rtl/peripheral_mult_if.sv
// Data-bus slice seen by the memory-mapped multiplier: chip select, byte address,
// write strobe, write data and combinational read data.
interface peripheral_mult_if;
   logic        cs;
   logic [4:0]  addr;
   logic        wr;
   logic [31:0] d_in;
   logic [31:0] d_out;

   modport master (output cs, addr, wr, d_in, input d_out);
   modport slave  (input cs, addr, wr, d_in, output d_out);
endinterface

// File: rtl/peripheral_mult.sv
// Memory-mapped 32x32->64 unsigned shift-and-add multiplier with fixed 32-cycle latency.
// state | meaning
// IDLE  | no product computed since reset; accepts start
// RUN   | one shift-and-add iteration per cycle; A/B/CTRL writes ignored
// DONE  | product latched in RES; done sticky until next start
module peripheral_mult #(
   parameter int WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   peripheral_mult_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] res;
   logic [4:0]         count;

   logic [2:0]         reg_sel;
   logic               wr_en;
   logic               start;
   logic               last_iter;
   logic               unused_bits;

   assign reg_sel     = bus.addr[4:2];
   assign wr_en       = bus.cs & bus.wr;
   assign unused_bits = ^bus.addr[1:0];

   assign start     = wr_en && (reg_sel == 3'd2) && bus.d_in[0] && (state != S_RUN);
   assign last_iter = (state == S_RUN) && (count == 5'd31);
   assign acc_next  = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (last_iter) state_next = S_DONE;
         S_DONE:  if (start) state_next = S_RUN;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         res    <= '0;
         count  <= '0;
      end else begin
         if (wr_en && (state != S_RUN)) begin
            if (reg_sel == 3'd0) op_a <= bus.d_in;
            if (reg_sel == 3'd1) op_b <= bus.d_in;
         end
         if (start) begin
            mcand  <= {{WIDTH{1'b0}}, op_a};
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
         end else if (state == S_RUN) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
         end
         // Product register only changes here, so the old result stays readable during RUN.
         if (last_iter) res <= acc_next;
      end
   end

   always_comb begin
      bus.d_out = '0;
      if (bus.cs) begin
         case (reg_sel)
            3'd0:    bus.d_out = op_a;
            3'd1:    bus.d_out = op_b;
            3'd3:    bus.d_out = {30'd0, (state == S_RUN), (state == S_DONE)};
            3'd4:    bus.d_out = res[WIDTH-1:0];
            3'd5:    bus.d_out = res[2*WIDTH-1:WIDTH];
            default: bus.d_out = '0;
         endcase
      end
   end

endmodule
